// File: rtl/regfile_sb_pkg.sv
// Shared constants for the register file / scoreboard slice.
//   REG_W     data word width
//   NREG_DEF  architectural register count (r0 hardwired to zero)
//   CNT_W_DEF pending-writer counter width per register
package regfile_sb_pkg;
  localparam int REG_W     = 32;
  localparam int NREG_DEF  = 32;
  localparam int CNT_W_DEF = 2;
  localparam logic [REG_W-1:0] ZERO_WORD = '0;
endpackage

// File: rtl/regfile_scoreboard.sv
// Pending-write scoreboard: one saturating counter per register, counting
// issued-but-not-retired writers, plus a sticky overflow flag and per-port
// busy (stall) outputs.
//   clk, rst              clock, async active-low reset
//   we, waddr             WB retire (decrements the destination counter)
//   issue_we, issue_addr  decode issue (increments the destination counter)
//   flush                 clears every counter; same-cycle issue is dropped
//   re1/raddr1, re2/raddr2  read ports whose operands are being checked
//   busy1, busy2          operand still pending, decode must stall
//   sb_overflow           sticky: issue hit a saturated counter
module regfile_scoreboard
  import regfile_sb_pkg::*;
#(
  parameter int NREG   = NREG_DEF,
  parameter int CNT_W  = CNT_W_DEF,
  parameter int ADDR_W = $clog2(NREG)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic              issue_we,
  input  logic [ADDR_W-1:0] issue_addr,
  input  logic              flush,
  input  logic              re1,
  input  logic [ADDR_W-1:0] raddr1,
  input  logic              re2,
  input  logic [ADDR_W-1:0] raddr2,
  output logic              busy1,
  output logic              busy2,
  output logic              sb_overflow
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [NREG-1:0][CNT_W-1:0] cnt, cnt_nxt;
  logic                       ovf_set;

  always_comb begin
    logic inc, dec;
    cnt_nxt = cnt;
    ovf_set = 1'b0;
    inc     = 1'b0;
    dec     = 1'b0;
    for (int r = 1; r < NREG; r++) begin
      inc = issue_we && (issue_addr == ADDR_W'(r)) && !flush;
      // WB of a flushed/untracked writer finds cnt==0 and is ignored.
      dec = we && (waddr == ADDR_W'(r)) && (cnt[r] != '0);
      if (flush)
        cnt_nxt[r] = '0;
      else if (inc && !dec) begin
        if (cnt[r] == CNT_MAX) ovf_set = 1'b1;
        else                   cnt_nxt[r] = cnt[r] + CNT_ONE;
      end else if (dec && !inc)
        cnt_nxt[r] = cnt[r] - CNT_ONE;
    end
    cnt_nxt[0] = '0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt         <= '0;
      sb_overflow <= 1'b0;
    end else begin
      cnt         <= cnt_nxt;
      sb_overflow <= sb_overflow | ovf_set;
    end
  end

  // A last outstanding writer retiring this cycle is bypassed by the
  // register file, so the operand is not busy.
  function automatic logic busy_of(input logic re, input logic [ADDR_W-1:0] a);
    return re && (a != '0) && (cnt[a] != '0) &&
           !((cnt[a] == CNT_ONE) && we && (waddr == a));
  endfunction

  assign busy1 = busy_of(re1, raddr1);
  assign busy2 = busy_of(re2, raddr2);

endmodule

// File: rtl/regfile_sb.sv
// General-purpose register file with two combinational read ports (write-
// through bypass from WB), one WB write port, and a pending-write scoreboard
// for RAW-hazard stalls in decode.
//   clk, rst                 clock, async active-low reset
//   we, waddr, wdata         WB write port (writes to r0 dropped)
//   re1/raddr1/rdata1        read port 1
//   re2/raddr2/rdata2        read port 2
//   issue_we, issue_addr     decode issue of a register writer
//   flush                    discard all in-flight writers
//   busy1, busy2             operand not yet available
//   sb_overflow              sticky scoreboard saturation flag
module regfile_sb
  import regfile_sb_pkg::*;
#(
  parameter int NREG  = NREG_DEF,
  parameter int CNT_W = CNT_W_DEF,
  localparam int ADDR_W = $clog2(NREG)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [REG_W-1:0]  wdata,
  input  logic              re1,
  input  logic [ADDR_W-1:0] raddr1,
  output logic [REG_W-1:0]  rdata1,
  input  logic              re2,
  input  logic [ADDR_W-1:0] raddr2,
  output logic [REG_W-1:0]  rdata2,
  input  logic              issue_we,
  input  logic [ADDR_W-1:0] issue_addr,
  input  logic              flush,
  output logic              busy1,
  output logic              busy2,
  output logic              sb_overflow
);

  logic [NREG-1:0][REG_W-1:0] rf;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      rf <= '0;
    else if (we && (waddr != '0))
      rf[waddr] <= wdata;
  end

  // Outputs forced to zero during reset so a live WB bypass cannot leak out.
  function automatic logic [REG_W-1:0] rd(input logic re, input logic [ADDR_W-1:0] a);
    if (!rst || !re || (a == '0)) return ZERO_WORD;
    if (we && (waddr == a))       return wdata;
    return rf[a];
  endfunction

  assign rdata1 = rd(re1, raddr1);
  assign rdata2 = rd(re2, raddr2);

  regfile_scoreboard #(.NREG(NREG), .CNT_W(CNT_W), .ADDR_W(ADDR_W)) u_sb (
    .clk        (clk),
    .rst        (rst),
    .we         (we),
    .waddr      (waddr),
    .issue_we   (issue_we),
    .issue_addr (issue_addr),
    .flush      (flush),
    .re1        (re1),
    .raddr1     (raddr1),
    .re2        (re2),
    .raddr2     (raddr2),
    .busy1      (busy1),
    .busy2      (busy2),
    .sb_overflow(sb_overflow)
  );

endmodule

// File: tb/tb_regfile_sb.sv
module tb_regfile_sb;
  logic        clk = 1'b0;
  logic        rst;
  logic        we, re1, re2, issue_we, flush;
  logic [4:0]  waddr, raddr1, raddr2, issue_addr;
  logic [31:0] wdata, rdata1, rdata2;
  logic        busy1, busy2, sb_overflow;
  int          nvec = 0;
  int          nerr = 0;

  always #5 clk = ~clk;

  regfile_sb dut (
    .clk(clk), .rst(rst),
    .we(we), .waddr(waddr), .wdata(wdata),
    .re1(re1), .raddr1(raddr1), .rdata1(rdata1),
    .re2(re2), .raddr2(raddr2), .rdata2(rdata2),
    .issue_we(issue_we), .issue_addr(issue_addr), .flush(flush),
    .busy1(busy1), .busy2(busy2), .sb_overflow(sb_overflow)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b0; we = 0; re1 = 0; re2 = 0; issue_we = 0; flush = 0;
    waddr = 0; raddr1 = 0; raddr2 = 0; issue_addr = 0; wdata = 0;
    tick(); tick();
    rst = 1'b1;
    #1;
    chk("rst_rdata1", rdata1, 32'h0);
    chk("rst_busy1", {31'b0, busy1}, 32'h0);
    chk("rst_ovf", {31'b0, sb_overflow}, 32'h0);

    // 1. reset mid-operation
    we = 1; waddr = 5; wdata = 32'h1234; issue_we = 1; issue_addr = 5;
    tick();
    we = 0; issue_we = 0; re1 = 1; raddr1 = 5;
    #1;
    chk("r5_written", rdata1, 32'h1234);
    chk("r5_busy", {31'b0, busy1}, 32'h1);
    we = 1; waddr = 5; wdata = 32'hAAAA;
    rst = 1'b0;
    #1;
    chk("midrst_rdata1", rdata1, 32'h0);
    chk("midrst_busy1", {31'b0, busy1}, 32'h0);
    chk("midrst_ovf", {31'b0, sb_overflow}, 32'h0);
    we = 0;
    tick();
    rst = 1'b1;
    #1;
    chk("r5_after_rst", rdata1, 32'h0);
    chk("busy_after_rst", {31'b0, busy1}, 32'h0);

    // 2. write/read with bypass
    we = 1; waddr = 3; wdata = 32'hDEADBEEF; re1 = 1; raddr1 = 3;
    #1;
    chk("bypass_r3", rdata1, 32'hDEADBEEF);
    tick();
    we = 0;
    #1;
    chk("stored_r3", rdata1, 32'hDEADBEEF);
    re1 = 0;
    #1;
    chk("re1_off", rdata1, 32'h0);

    // 3. r0
    we = 1; waddr = 0; wdata = 32'hFFFFFFFF; issue_we = 1; issue_addr = 0;
    re1 = 1; raddr1 = 0;
    #1;
    chk("r0_bypass", rdata1, 32'h0);
    tick();
    we = 0; issue_we = 0;
    #1;
    chk("r0_read", rdata1, 32'h0);
    chk("r0_busy", {31'b0, busy1}, 32'h0);

    // 4. RAW hazard on r7
    issue_we = 1; issue_addr = 7; raddr1 = 7; re2 = 1; raddr2 = 7;
    #1;
    chk("r7_busy_issue_cyc", {31'b0, busy1}, 32'h0);
    tick();
    issue_we = 0;
    #1;
    chk("r7_busy1_N+1", {31'b0, busy1}, 32'h1);
    chk("r7_busy2_N+1", {31'b0, busy2}, 32'h1);
    tick();
    chk("r7_busy_hold", {31'b0, busy1}, 32'h1);
    we = 1; waddr = 7; wdata = 32'h0000_0077;
    #1;
    chk("r7_wb_busy", {31'b0, busy1}, 32'h0);
    chk("r7_wb_data", rdata1, 32'h77);
    tick();
    we = 0;
    #1;
    chk("r7_after_busy", {31'b0, busy2}, 32'h0);
    chk("r7_after_data", rdata2, 32'h77);
    re2 = 0;

    // 5. counting and saturation on r9
    raddr1 = 9; issue_we = 1; issue_addr = 9;
    tick(); tick(); tick();
    issue_we = 0;
    #1;
    chk("r9_ovf_cnt3", {31'b0, sb_overflow}, 32'h0);
    chk("r9_busy_cnt3", {31'b0, busy1}, 32'h1);
    issue_we = 1;
    tick();
    issue_we = 0;
    #1;
    chk("r9_ovf_set", {31'b0, sb_overflow}, 32'h1);
    we = 1; waddr = 9; wdata = 32'h1;
    #1;
    chk("r9_wb1_busy", {31'b0, busy1}, 32'h1);
    tick();
    wdata = 32'h2;
    #1;
    chk("r9_wb2_busy", {31'b0, busy1}, 32'h1);
    tick();
    wdata = 32'h3;
    #1;
    chk("r9_wb3_busy", {31'b0, busy1}, 32'h0);
    chk("r9_wb3_data", rdata1, 32'h3);
    tick();
    we = 0;
    #1;
    chk("r9_done_busy", {31'b0, busy1}, 32'h0);
    chk("r9_done_data", rdata1, 32'h3);
    chk("ovf_sticky", {31'b0, sb_overflow}, 32'h1);

    // clear the sticky flag before flush checks
    rst = 1'b0;
    #1;
    chk("ovf_cleared", {31'b0, sb_overflow}, 32'h0);
    rst = 1'b1;

    // 6. flush with cnt[4]=2 and a same-cycle issue to r4
    re2 = 1; raddr2 = 4; issue_we = 1; issue_addr = 4;
    tick(); tick();
    flush = 1;
    #1;
    chk("r4_busy_cnt2", {31'b0, busy2}, 32'h1);
    tick();
    flush = 0; issue_we = 0;
    #1;
    chk("r4_busy_flushed", {31'b0, busy2}, 32'h0);
    we = 1; waddr = 4; wdata = 32'h44;
    #1;
    chk("r4_wb_bypass", rdata2, 32'h44);
    tick();
    we = 0;
    #1;
    chk("r4_wb_stored", rdata2, 32'h44);
    chk("r4_no_err", {31'b0, sb_overflow}, 32'h0);
    // counter must be 0 (not wrapped): one issue yields cnt==1
    issue_we = 1;
    tick();
    issue_we = 0;
    #1;
    chk("r4_cnt1_busy", {31'b0, busy2}, 32'h1);
    // simultaneous issue and retire keeps cnt at 1
    issue_we = 1; we = 1; waddr = 4; wdata = 32'h55;
    tick();
    issue_we = 0; we = 0;
    #1;
    chk("r4_incdec_busy", {31'b0, busy2}, 32'h1);
    chk("r4_incdec_data", rdata2, 32'h55);
    we = 1; wdata = 32'h66;
    tick();
    we = 0;
    #1;
    chk("r4_final_busy", {31'b0, busy2}, 32'h0);
    chk("r4_final_data", rdata2, 32'h66);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
